// File: rtl/aes_round_sched.sv
// Purpose : sequences ByteSub_ShiftRow / MixColumn / AddRoundKey over one AES block via ap_ctrl_hs.
// Latency : 1 + sum(k_i + 1) cycles over the 3*NR child ops (k_i = child done delay, k_i >= 1).
// Backpr. : each op waits for the selected child's done; ap_start is only sampled in IDLE.
//
// Ports:
//   ap_clk, ap_rst                  clock, asynchronous active-high reset
//   ap_start/ap_done/ap_ready/ap_idle  block-level ap_ctrl_hs handshake (done/ready are 1-cycle pulses)
//   sub_start/sub_done              ByteSub_ShiftRow handshake
//   mix_start/mix_done              MixColumn handshake
//   ark_start/ark_done, ark_n       AddRoundKey handshake and its round index
//   round                           round of the op in flight
//   err                             sticky watchdog abort flag
//
// Optional feature: define AES_RND_WATCHDOG_EN to abort a child op after WDOG_CYC
// wait cycles without done. Without it, err is constant 0 and WAIT never times out.
module aes_round_sched #(
    parameter int NR       = 10,
    parameter int WDOG_CYC = 255
) (
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic       ap_start,
    output logic       ap_done,
    output logic       ap_ready,
    output logic       ap_idle,
    output logic       sub_start,
    input  logic       sub_done,
    output logic       mix_start,
    input  logic       mix_done,
    output logic       ark_start,
    input  logic       ark_done,
    output logic [5:0] ark_n,
    output logic [3:0] round,
    output logic       err
);

    // Op index is wide enough for all 3*NR ops (5 bits for NR=10).
    localparam int NOPS = 3 * NR;
    localparam int OPW  = $clog2(NOPS);
    localparam logic [OPW-1:0] LAST_OP = OPW'(NOPS - 1);

    // round is 4 bits wide and the watchdog counter 8 bits wide.
    if (NR < 2 || NR > 15) begin : g_bad_nr
        $error("aes_round_sched: NR must be in 2..15");
    end
    if (WDOG_CYC < 1 || WDOG_CYC > 255) begin : g_bad_wdog
        $error("aes_round_sched: WDOG_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {C_SUB, C_MIX, C_ARK} child_t;

    // Op 0 is the initial AddRoundKey. Round r >= 1 starts at op 3r-2 with
    // SUB, MIX, ARK; the final round has no MIX, so its second op is ARK.
    function automatic child_t child_of(input logic [OPW-1:0] op, input logic [3:0] rnd);
        child_t c;
        int     pos;
        pos = int'(op) - 3 * int'(rnd) + 2;
        if (op == '0)
            c = C_ARK;
        else if (pos == 0)
            c = C_SUB;
        else if (pos == 1 && int'(rnd) != NR)
            c = C_MIX;
        else
            c = C_ARK;
        return c;
    endfunction

    state_t         state;
    logic [OPW-1:0] op_idx;

    child_t         cur_child;
    child_t         nxt_child;
    logic [OPW-1:0] nxt_op;
    logic [3:0]     nxt_round;
    logic           cur_done;

    always_comb begin
        cur_child = child_of(op_idx, round);
        nxt_op    = op_idx + 1'b1;
        // The round only advances once its AddRoundKey has completed.
        nxt_round = (cur_child == C_ARK) ? round + 4'd1 : round;
        nxt_child = child_of(nxt_op, nxt_round);
        // Only the selected child's done counts; others may be asserted freely.
        case (cur_child)
            C_SUB:   cur_done = sub_done;
            C_MIX:   cur_done = mix_done;
            default: cur_done = ark_done;
        endcase
    end

`ifdef AES_RND_WATCHDOG_EN
    logic [7:0] wdog_cnt;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= S_IDLE;
            op_idx    <= '0;
            round     <= '0;
            ark_n     <= '0;
            sub_start <= 1'b0;
            mix_start <= 1'b0;
            ark_start <= 1'b0;
            ap_done   <= 1'b0;
            ap_ready  <= 1'b0;
            ap_idle   <= 1'b1;
`ifdef AES_RND_WATCHDOG_EN
            wdog_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state     <= S_ISSUE;
                        ap_idle   <= 1'b0;
                        op_idx    <= '0;
                        round     <= '0;
                        ark_n     <= '0;
                        ark_start <= 1'b1;
`ifdef AES_RND_WATCHDOG_EN
                        err_q     <= 1'b0;
`endif
                    end
                end

                // The start raised on entry is held; done is not looked at yet.
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef AES_RND_WATCHDOG_EN
                    wdog_cnt <= '0;
`endif
                end

                S_WAIT: begin
                    if (cur_done) begin
                        sub_start <= 1'b0;
                        mix_start <= 1'b0;
                        ark_start <= 1'b0;
                        if (op_idx == LAST_OP) begin
                            state    <= S_DONE;
                            ap_done  <= 1'b1;
                            ap_ready <= 1'b1;
                        end else begin
                            // Single NEXT decision: op index and round advance together.
                            op_idx <= nxt_op;
                            round  <= nxt_round;
                            state  <= S_ISSUE;
                            case (nxt_child)
                                C_SUB:   sub_start <= 1'b1;
                                C_MIX:   mix_start <= 1'b1;
                                default: begin
                                    ark_start <= 1'b1;
                                    ark_n     <= {2'b00, nxt_round};
                                end
                            endcase
                        end
                    end
`ifdef AES_RND_WATCHDOG_EN
                    else if (wdog_cnt == 8'(WDOG_CYC)) begin
                        sub_start <= 1'b0;
                        mix_start <= 1'b0;
                        ark_start <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= S_DONE;
                        ap_done   <= 1'b1;
                        ap_ready  <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 8'd1;
                    end
`endif
                end

                S_DONE: begin
                    ap_done  <= 1'b0;
                    ap_ready <= 1'b0;
                    ap_idle  <= 1'b1;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: open-loop child responders driven from a precomputed
// op schedule, with a per-cycle comparison of every output against that schedule.
module tb_aes_round_sched;

    localparam int NR   = 10;
    localparam int MAXC = 700;

    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic       ap_start;
    logic       ap_done, ap_ready, ap_idle;
    logic       sub_start, mix_start, ark_start;
    logic       sub_done, mix_done, ark_done;
    logic [5:0] ark_n;
    logic [3:0] round;
    logic       err;

    always #5 ap_clk = ~ap_clk;

    aes_round_sched #(.NR(NR), .WDOG_CYC(16)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .sub_start(sub_start),
        .sub_done (sub_done),
        .mix_start(mix_start),
        .mix_done (mix_done),
        .ark_start(ark_start),
        .ark_done (ark_done),
        .ark_n    (ark_n),
        .round    (round),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;
    int done_cnt, first_done, last_done;

    // Child codes: 0 = SUB, 1 = MIX, 2 = ARK.
    typedef struct {int ch; int rnd;} op_t;
    op_t ops[$];

    bit exp_st [3][MAXC];
    bit exp_done [MAXC];
    bit exp_idle [MAXC];
    int exp_round [MAXC];
    int exp_arkn [MAXC];
    bit drv_dn [3][MAXC];
    bit drv_start [MAXC];
    int model_done [2];

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    // Single compare process: every output, every scheduled cycle.
    always @(negedge ap_clk) begin
        if (chk_en) begin
            chk("sub_start", int'(sub_start), int'(exp_st[0][cyc]));
            chk("mix_start", int'(mix_start), int'(exp_st[1][cyc]));
            chk("ark_start", int'(ark_start), int'(exp_st[2][cyc]));
            chk("round",     int'(round),     exp_round[cyc]);
            chk("ark_n",     int'(ark_n),     exp_arkn[cyc]);
            chk("ap_done",   int'(ap_done),   int'(exp_done[cyc]));
            chk("ap_ready",  int'(ap_ready),  int'(exp_done[cyc]));
            chk("ap_idle",   int'(ap_idle),   int'(exp_idle[cyc]));
            chk("err",       int'(err),       0);
            chk("one_start", int'((int'(sub_start) + int'(mix_start) + int'(ark_start)) <= 1), 1);
            if (ap_done) begin
                if (done_cnt == 0) first_done = cyc;
                last_done = cyc;
                done_cnt++;
            end
        end
    end

    task automatic drive_idle();
        ap_start = 1'b0;
        sub_done = 1'b0;
        mix_done = 1'b0;
        ark_done = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 0;
        drive_idle();
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    // Build the expected timeline from the op list and per-op done delays,
    // then replay it cycle by cycle. kfix=0 picks random delays 1..6.
    // idmode: 0 none, 1 always, 2 random done in the ISSUE cycle.
    // nmode : 0 quiet, 1 random, 2 held-high done while a child's start is low.
    task automatic run(input int nblk, input int kfix, input int idmode,
                       input int nmode, input int stop_at);
        int s, t, k, endc, ch, r;
        for (int c = 0; c < MAXC; c++) begin
            exp_done[c] = 0; exp_idle[c] = 1; exp_round[c] = 0; exp_arkn[c] = 0;
            drv_start[c] = 0;
            for (int j = 0; j < 3; j++) begin
                exp_st[j][c] = 0;
                drv_dn[j][c] = 0;
            end
        end
        s = 0;
        for (int b = 0; b < nblk; b++) begin
            t = s + 1;
            foreach (ops[i]) begin
                k  = (kfix == 0) ? int'($urandom_range(1, 6)) : kfix;
                ch = ops[i].ch;
                r  = ops[i].rnd;
                for (int c = t; c <= t + k; c++) begin
                    exp_st[ch][c] = 1;
                    exp_idle[c]   = 0;
                end
                for (int c = t; c < MAXC; c++) begin
                    exp_round[c] = r;
                    if (ch == 2) exp_arkn[c] = r;
                end
                drv_dn[ch][t + k] = 1;
                if (idmode == 1 || (idmode == 2 && $urandom_range(0, 1) == 1))
                    drv_dn[ch][t] = 1;
                t += k + 1;
            end
            exp_done[t] = 1;
            exp_idle[t] = 0;
            model_done[b] = t;
            // ap_start is 1 at acceptance; random while busy (must be ignored),
            // or held high throughout for back-to-back blocks.
            for (int c = s; c <= t; c++)
                drv_start[c] = (c == s || nblk > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            s = t + 1;
        end
        endc = s + 2;
        for (int c = 0; c <= endc; c++)
            for (int j = 0; j < 3; j++)
                if (!exp_st[j][c]) begin
                    if (nmode == 2) drv_dn[j][c] = 1;
                    else if (nmode == 1) drv_dn[j][c] = 1'($urandom_range(0, 1));
                end
        done_cnt = 0; first_done = -1; last_done = -1;
        for (int c = 0; c <= endc; c++) begin
            @(posedge ap_clk);
            #1;
            cyc      = c;
            ap_start = drv_start[c];
            sub_done = drv_dn[0][c];
            mix_done = drv_dn[1][c];
            ark_done = drv_dn[2][c];
            chk_en   = 1;
            if (c == stop_at) return;
        end
        @(posedge ap_clk);
        #1;
        chk_en = 0;
        drive_idle();
    endtask

    initial begin
        int n;
        int mix_last;

        // Op list straight from the round structure.
        ops.push_back('{2, 0});
        for (int r = 1; r < NR; r++) begin
            ops.push_back('{0, r});
            ops.push_back('{1, r});
            ops.push_back('{2, r});
        end
        ops.push_back('{0, NR});
        ops.push_back('{2, NR});

        chk("model_nops", ops.size(), 30);
        n = 0;
        mix_last = 0;
        foreach (ops[i]) begin
            if (ops[i].ch == 2) begin
                chk("model_ark_seq", ops[i].rnd, n);
                n++;
            end
            if (ops[i].ch == 1 && ops[i].rnd == NR) mix_last++;
        end
        chk("model_mix_in_last_round", mix_last, 0);

        // Reset values, checked while reset is asserted.
        drive_idle();
        ap_rst = 1'b1;
        #12;
        chk("rst_idle",  int'(ap_idle), 1);
        chk("rst_done",  int'(ap_done), 0);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_starts", int'({sub_start, mix_start, ark_start}), 0);
        chk("rst_ark_n", int'(ark_n), 0);
        chk("rst_round", int'(round), 0);
        chk("rst_err",   int'(err), 0);

        // All children answer at k=3.
        do_reset();
        run(1, 3, 0, 0, -1);
        chk("model_done_k3", model_done[0], 121);
        chk("dut_done_k3", last_done, 121);
        chk("dut_done_cnt_k3", done_cnt, 1);

        // Children hold done high whenever their start is low.
        do_reset();
        run(1, 3, 0, 2, -1);
        chk("dut_done_held", last_done, 121);
        chk("dut_done_cnt_held", done_cnt, 1);

        // Done in the ISSUE cycle is ignored; real done at k=2 -> 3 cycles per op.
        do_reset();
        run(1, 2, 1, 0, -1);
        chk("model_done_issue", model_done[0], 91);
        chk("dut_done_issue", last_done, 91);

        // ap_start held high: back-to-back blocks.
        do_reset();
        run(2, 3, 0, 0, -1);
        chk("model_b2b_issue2", int'(exp_st[2][123]), 1);
        chk("model_b2b_done2", model_done[1], 243);
        chk("dut_b2b_done1", first_done, 121);
        chk("dut_b2b_done2", last_done, 243);
        chk("dut_b2b_cnt", done_cnt, 2);

        // Random delays, random noise on unselected/idle done lines.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            run(1, 0, 2, 1, -1);
            chk("dut_done_rand", last_done, model_done[0]);
            chk("dut_done_cnt_rand", done_cnt, 1);
        end

        // Reset during WAIT of round-4 MixColumn (issued at cycle 45).
        do_reset();
        run(1, 3, 0, 0, 46);
        #3;
        chk("rst_mid_pre_mix", int'(mix_start), 1);
        chk_en = 0;
        drive_idle();
        ap_rst = 1'b1;
        #1;
        chk("rst_mid_mix",   int'(mix_start), 0);
        chk("rst_mid_idle",  int'(ap_idle), 1);
        chk("rst_mid_round", int'(round), 0);
        chk("rst_mid_done",  int'(ap_done), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ap_clk);
            chk("rst_mid_no_done", int'(ap_done), 0);
            chk("rst_mid_stay_idle", int'(ap_idle), 1);
        end

`ifdef AES_RND_WATCHDOG_EN
        begin : wdog_test
            int rise;
            int dn;
            rise = -1;
            dn   = -1;
            do_reset();
            for (int c = 0; c < 200; c++) begin
                @(posedge ap_clk);
                #1;
                cyc      = c;
                ap_start = (c == 0 || (dn >= 0 && c == dn + 3)) ? 1'b1 : 1'b0;
                sub_done = sub_start;
                ark_done = ark_start;
                mix_done = 1'b0;
                @(negedge ap_clk);
                if (mix_start && rise < 0) rise = c;
                if (ap_done && dn < 0) begin
                    dn = c;
                    chk("wdog_err_at_done", int'(err), 1);
                end
                if (dn >= 0 && c == dn + 2) chk("wdog_err_sticky", int'(err), 1);
                if (dn >= 0 && c == dn + 4) begin
                    chk("wdog_err_cleared", int'(err), 0);
                    break;
                end
            end
            chk("wdog_mix_rise", rise, 5);
            chk("wdog_done_delay", dn - rise, 18);
            drive_idle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
